serial_frame_rx: RTL
====================

# serial_frame_rx

Receive-side companion to the team's parallel-load shift register. It consumes a serial bitstream of the kind that register emits when driven as a UART-style transmitter, and recovers framed words. It detects a start bit, samples `BIT` data bits LSB-first at mid-bit, checks the stop bit (and optional parity), and presents each recovered word on a parallel bus with a one-cycle valid strobe.

## Interface
- `BIT`, 8: data bits per frame; must be ≥ 2.
- `CLKS_PER_BIT`, 4: `i_clk` cycles per serial bit; must be ≥ 2. `HALF` = `CLKS_PER_BIT/2` (integer division).
- `i_clk`  input  1  single clock; all logic is on the posedge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_serial`  input  1  serial line; idles high. Asynchronous to the frame; synchronized internally.
- `o_parrel`  output  `BIT`  last good received word; bit 0 is the first data bit received.
- `o_valid`  output  1  one-cycle pulse; `o_parrel` is updated in the same cycle.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit samples 0.
- `o_parity_err`  output  1  one-cycle pulse on parity mismatch; constant 0 without the macro.
- `o_busy`  output  1  high whenever the FSM is not in `IDLE`.

## Operation
- **Synchronizer:** 2-flop chain on `i_serial`; both flops reset to 1. The FSM sees only the synchronized line `rx`.
- **Counters:** `cnt` is a bit-period counter of width `$clog2(CLKS_PER_BIT)+1`. `idx` is a data-bit index of width `$clog2(BIT)+1`. Shift register `sr[BIT-1:0]` shifts right, with the new bit entering at the MSB, so the first bit received ends at `sr[0]`.
- **`IDLE`:** if `rx==0`, go to `START` with `cnt=0`.
- **`START`:** when `cnt==HALF-1`, sample `rx`.
  - `rx==1`: treat as a glitch. Return to `IDLE` with no flag.
  - `rx==0`: go to `DATA` with `cnt=0`, `idx=0`.
- **`DATA`:** when `cnt==CLKS_PER_BIT-1`, shift `rx` into `sr`, set `cnt=0`, increment `idx`. After the `BIT`-th sample, go to `PARITY` (macro defined) or `STOP`.
- **`PARITY`:** sample after one bit period and compare against even parity of `sr`. Then go to `STOP`.
- **`STOP`:** sample after one bit period.
  - `rx==1`, parity ok: load `o_parrel<=sr`, pulse `o_valid`, go to `IDLE`.
  - `rx==1`, parity bad: pulse `o_parity_err`, leave `o_parrel` unchanged, go to `IDLE`.
  - `rx==0`: pulse `o_frame_err` (it has priority over the parity error), leave `o_parrel` unchanged, go to `WAIT_HIGH`.
- **`WAIT_HIGH`:** stay until `rx==1`, then go to `IDLE`. This prevents a stuck-low line from retriggering a frame.
- **Reset (any cycle, including mid-frame):** FSM to `IDLE`. `cnt`, `idx`, `sr`, `o_parrel`, `o_valid`, `o_frame_err`, `o_parity_err` and `o_busy` all go to 0; synchronizer flops go to 1. A partially received frame is discarded with no strobe.
- **Strobes:** `o_valid`, `o_frame_err` and `o_parity_err` are mutually exclusive and high for exactly one cycle.

## Timing
- Let edge E0 be the first posedge at which sync flop 1 captures 0.
- The FSM leaves `IDLE` at E2. The start sample is at E2+`HALF`. Data bit k (k = 1..`BIT`) is sampled at E2+`HALF`+k·`CLKS_PER_BIT`.
- The stop sample is at E2+`HALF`+(`BIT`+1)·`CLKS_PER_BIT`, plus `CLKS_PER_BIT` with parity. The strobe is registered and is high in the cycle following that edge.
- With defaults (`BIT`=8, `CLKS_PER_BIT`=4, no parity), `o_valid` rises after E40.
- Back-to-back frames are supported: a start bit immediately after a 1-bit-period stop is received without loss, because the FSM returns to `IDLE` at the stop sample, mid-stop-bit.
- `o_busy` rises the cycle after E2 and falls with the strobe cycle. In `WAIT_HIGH`, `o_busy` stays high.

## Configuration
- Macro: `SERIAL_RX_PARITY_EN`.
- **Defined:** frame is start, `BIT` data bits, even-parity bit, stop. Parity is checked and `o_parity_err` is driven. Frame length is `BIT`+3 bit periods.
- **Undefined:** frame is start, `BIT` data bits, stop. There is no `PARITY` state, and `o_parity_err` is tied to 0. The port list is identical in both builds.

## Test plan
All scenarios use defaults (`CLKS_PER_BIT`=4, 4 cycles per bit) unless noted.
- **Single frame:** frame 0x55 -> `o_parrel`=0x55, `o_valid` high exactly 1 cycle after E40, `o_busy` low the next cycle.
- **Back-to-back:** frames 0xC3 then 0x0F with no idle gap -> two `o_valid` pulses 40 cycles apart; `o_parrel` reads 0xC3, then 0x0F.
- **Glitch:** `i_serial` low for 1 cycle then high -> no strobe. `o_busy` pulses for `HALF` cycles, and the FSM is back in `IDLE`.
- **Framing error:** frame 0xAA with stop bit 0, line then held low 20 cycles before going high -> `o_frame_err` 1 cycle, `o_valid` never asserted, `o_parrel` keeps its prior value. After the line goes high, a following 0x5A frame is received.
- **Reset mid-frame:** assert `i_rst` for 1 cycle during data bit 4 of 0xFF -> all outputs 0 the next cycle, no strobe. A subsequent 0x81 frame gives `o_parrel`=0x81.
- **Parity (`SERIAL_RX_PARITY_EN`):** 0x07 with parity bit 1 -> `o_valid`, `o_parrel`=0x07. The same frame with parity bit 0 -> `o_parity_err` 1 cycle, no `o_valid`, `o_parrel` unchanged.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: UART-style serial frame receiver.
// It synchronizes the serial line, finds the start bit, and samples BIT data bits
// LSB-first in the middle of each bit. It then checks the stop bit and, when enabled,
// an even-parity bit. Each good word is presented on o_parrel together with a
// one-cycle o_valid pulse.
// Optional feature macro: SERIAL_RX_PARITY_EN.
// - Defined: the frame carries an even-parity bit between the data and the stop bit.
// - Undefined: there is no parity bit, and o_parity_err is tied low.
`timescale 1ns/1ps

module serial_frame_rx #(
    parameter int BIT          = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_serial,
    output logic [BIT-1:0] o_parrel,
    output logic           o_valid,
    output logic           o_frame_err,
    output logic           o_parity_err,
    output logic           o_busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW   = $clog2(BIT) + 1;

    localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST      = IW'(BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd3;
`endif

    logic [1:0]     sync_q;
    logic           rx;
    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [BIT-1:0] sr_q, sr_d;
    logic [BIT-1:0] parrel_q, parrel_d;
    logic           valid_q, valid_d;
    logic           frame_err_q, frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
    logic           parity_bad_q, parity_bad_d;
    logic           parity_err_q, parity_err_d;
`endif

    assign rx = sync_q[1];

    // Two-flop synchronizer. Both flops reset to the idle (high) level so that
    // leaving reset cannot look like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_serial};
        end
    end

    // Frame FSM: bit-period timing, data shifting, and the stop/parity decision.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sr_d        = sr_q;
        parrel_d    = parrel_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        // The line went back high before mid-start-bit: treat it as a glitch.
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    sr_d  = {rx, sr_q[BIT-1:1]};
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d        = '0;
                    parity_bad_d = rx ^ (^sr_q);
                    state_d      = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx) begin
                        // A framing error takes priority over a parity error.
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (parity_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
`endif
                    end else begin
                        // Returning to IDLE in the middle of the stop bit lets a
                        // back-to-back start bit be caught.
                        parrel_d = sr_q;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // A stuck-low line must not retrigger a frame.
                if (rx) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and datapath registers. Reset discards any partial frame without a strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sr_q        <= '0;
            parrel_q    <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sr_q        <= sr_d;
            parrel_q    <= parrel_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign o_parrel    = parrel_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
